reg_wr_arb_rr: RTL

REG_WR_ARB_RR -- requirements
Module: reg_wr_arb_rr

---
 rtl/reg_wr_arb_rr.sv | 109 ++++++++++
 1 files changed

// File: rtl/reg_wr_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wr_arb_rr
//  Brief    : Round-robin arbiter granting one requester per two-cycle
//             IDLE/WRITE sequence to update a single shared register.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arb_rr #(
    parameter int DATA_WIDTH = 32,
    parameter int REQ_NUM    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [REQ_NUM-1:0]            i_req,
    input  logic [REQ_NUM*DATA_WIDTH-1:0] i_data,
    output logic [REQ_NUM-1:0]            o_gnt,
    output logic [REQ_NUM-1:0]            o_ack,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic [$clog2(REQ_NUM)-1:0]    o_owner,
    output logic                          o_valid,
    output logic                          o_busy
);

    localparam int PTR_W = $clog2(REQ_NUM);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [0:0]            r_state;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_winner;
    logic [REQ_NUM-1:0]    r_gnt;
    logic [REQ_NUM-1:0]    r_ack;
    logic [DATA_WIDTH-1:0] r_data;
    logic [PTR_W-1:0]      r_owner;
    logic                  r_valid;
    logic                  r_busy;

    int                    w_idx;
    logic [PTR_W-1:0]      w_cand;
    logic [PTR_W-1:0]      w_win;

    // Scan offsets from highest to lowest so the nearest set bit above ptr
    // is the last one written and therefore wins.
    always_comb begin
        w_idx  = 0;
        w_cand = '0;
        w_win  = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= REQ_NUM) begin
                w_idx = w_idx - REQ_NUM;
            end
            w_cand = w_idx[PTR_W-1:0];
            if (i_req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_data   <= '0;
            r_owner  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_gnt    <= REQ_NUM'(1) << w_win;
                        r_winner <= w_win;
                        r_busy   <= 1'b1;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Commit unconditionally: the winner may already have dropped its request.
                    r_data  <= i_data[int'(r_winner)*DATA_WIDTH +: DATA_WIDTH];
                    r_owner <= r_winner;
                    r_valid <= 1'b1;
                    r_ack   <= r_gnt;
                    r_ptr   <= (r_winner == PTR_W'(REQ_NUM - 1)) ? '0 : r_winner + 1'b1;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt   = r_gnt;
    assign o_ack   = r_ack;
    assign o_data  = r_data;
    assign o_owner = r_owner;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule
`default_nettype wire
